// File: rtl/mips_mul_pkg.sv
// Shared types and constants for the MIPS HI/LO multiply unit.
//   state_e      : multiply sequencer states
//   HALF_W/ACC_W : partial-product operand width and accumulator width
//   FUNCT_MULT*  : R-type funct codes, for the decoder that drives start/is_signed
//   abs32        : magnitude of a 32-bit two's-complement value
package mips_mul_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CALC = 2'd1,
    ST_FIX  = 2'd2
  } state_e;

  localparam int HALF_W = 16;
  localparam int ACC_W  = 64;

  localparam logic [5:0] FUNCT_MULT  = 6'h18;
  localparam logic [5:0] FUNCT_MULTU = 6'h19;

  // -0x80000000 wraps back to 0x80000000, which is the correct unsigned
  // magnitude, so no special case is needed.
  function automatic logic [31:0] abs32(input logic [31:0] v);
    return v[31] ? (~v + 32'd1) : v;
  endfunction

endpackage

// File: rtl/mul16x16_u.sv
// Combinational 16x16 unsigned multiplier.
//   x_i, y_i : unsigned operands
//   p_o      : full 32-bit product
module mul16x16_u
  import mips_mul_pkg::*;
(
  input  logic [HALF_W-1:0]   x_i,
  input  logic [HALF_W-1:0]   y_i,
  output logic [2*HALF_W-1:0] p_o
);

  assign p_o = {{HALF_W{1'b0}}, x_i} * {{HALF_W{1'b0}}, y_i};

endmodule

// File: rtl/mul_hilo_unit.sv
// Sequential 32x32 multiplier with the architectural HI/LO pair.
// Four passes through one 16x16 unsigned multiplier build the 64-bit
// magnitude product; a final FIX cycle applies the sign and writes HI/LO.
//   clk, rst_n        : clock, async active-low reset
//   start, is_signed  : launch MULT (is_signed=1) / MULTU, sampled in IDLE
//   a, b              : rs / rt operands
//   mthi, mtlo, wdata : HI/LO writes, honoured only in IDLE without start
//   busy              : multiply in flight (stall)
//   done              : one-cycle pulse once HI/LO hold the new product
//   hi, lo            : HI/LO registers
module mul_hilo_unit
  import mips_mul_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              is_signed,
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  input  logic              mthi,
  input  logic              mtlo,
  input  logic [DATA_W-1:0] wdata,
  output logic              busy,
  output logic              done,
  output logic [DATA_W-1:0] hi,
  output logic [DATA_W-1:0] lo
);

  localparam int H = DATA_W / 2;

  state_e             state_q;
  logic [1:0]         pass_q;
  logic [DATA_W-1:0]  ua_q, ub_q;
  logic               neg_q;
  logic [ACC_W-1:0]   acc_q;
  logic [DATA_W-1:0]  hi_q, lo_q;
  logic               done_q;

  logic [H-1:0]       op_x, op_y;
  logic [2*H-1:0]     pp;
  logic [ACC_W-1:0]   pp_sh;
  logic [ACC_W-1:0]   acc_d;
  logic [ACC_W-1:0]   res_d;

  // pass[1] picks the half of ua, pass[0] the half of ub:
  // 0: lo*lo, 1: lo*hi, 2: hi*lo, 3: hi*hi.
  always_comb begin
    op_x = pass_q[1] ? ua_q[DATA_W-1:H] : ua_q[H-1:0];
    op_y = pass_q[0] ? ub_q[DATA_W-1:H] : ub_q[H-1:0];
  end

  mul16x16_u u_mul (
    .x_i (op_x),
    .y_i (op_y),
    .p_o (pp)
  );

  // Weight of the partial product is the sum of the two half offsets.
  always_comb begin
    pp_sh = '0;
    case (pass_q)
      2'd0:    pp_sh = {{(ACC_W-2*H){1'b0}}, pp};
      2'd1,
      2'd2:    pp_sh = {{(ACC_W-2*H){1'b0}}, pp} << H;
      default: pp_sh = {{(ACC_W-2*H){1'b0}}, pp} << (2*H);
    endcase
  end

  assign acc_d = acc_q + pp_sh;
  assign res_d = neg_q ? (~acc_q + {{(ACC_W-1){1'b0}}, 1'b1}) : acc_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      pass_q  <= 2'd0;
      ua_q    <= '0;
      ub_q    <= '0;
      neg_q   <= 1'b0;
      acc_q   <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
      done_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (start) begin
            // start takes priority; a coincident MTHI/MTLO is dropped
            ua_q    <= is_signed ? abs32(a) : a;
            ub_q    <= is_signed ? abs32(b) : b;
            neg_q   <= is_signed & (a[DATA_W-1] ^ b[DATA_W-1]);
            acc_q   <= '0;
            pass_q  <= 2'd0;
            state_q <= ST_CALC;
          end else begin
            if (mthi) hi_q <= wdata;
            if (mtlo) lo_q <= wdata;
          end
        end
        ST_CALC: begin
          acc_q  <= acc_d;
          pass_q <= pass_q + 2'd1;
          if (pass_q == 2'd3) state_q <= ST_FIX;
        end
        ST_FIX: begin
          {hi_q, lo_q} <= res_d;
          done_q       <= 1'b1;
          state_q      <= ST_IDLE;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign busy = (state_q != ST_IDLE);
  assign done = done_q;
  assign hi   = hi_q;
  assign lo   = lo_q;

endmodule
